// File: rtl/operand_register_file_pkg.sv
// Shared encodings for the operand register file: register operations
// and the 3-bit source selects used by the two read ports.
package operand_register_file_pkg;

  localparam int unsigned DATA_W   = 16;
  localparam int unsigned NUM_REGS = 8;
  localparam int unsigned SEL_W    = 3;
  localparam int unsigned FUN_W    = 3;

  // Operation applied by every enabled register on a clock edge.
  typedef enum logic [FUN_W-1:0] {
    DEC         = 3'b000,  // value - 1, wraps 0000 -> FFFF
    INC         = 3'b001,  // value + 1, wraps FFFF -> 0000
    LOAD        = 3'b010,  // load full word I
    CLR         = 3'b011,  // clear to zero
    LOADLO_CLR  = 3'b100,  // {00, I[7:0]}
    WRLO        = 3'b101,  // replace low byte, keep high byte
    WRHI        = 3'b110,  // replace high byte with I[7:0], keep low byte
    LOADLO_SEXT = 3'b111   // sign-extended I[7:0]
  } fun_sel_e;

  // Read-port source select: general registers first, then scratch.
  typedef enum logic [SEL_W-1:0] {
    SEL_R1 = 3'b000,
    SEL_R2 = 3'b001,
    SEL_R3 = 3'b010,
    SEL_R4 = 3'b011,
    SEL_S1 = 3'b100,
    SEL_S2 = 3'b101,
    SEL_S3 = 3'b110,
    SEL_S4 = 3'b111
  } reg_sel_e;

endpackage

// File: rtl/operand_register_file_register16.sv
// One 16-bit register with an active-high enable; applies FunSel on each
// rising edge while enabled. Unknown FunSel codes leave the value held.
module register16
  import operand_register_file_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             E,
  input  logic [FUN_W-1:0] FunSel,
  input  logic [WIDTH-1:0] I,
  output logic [WIDTH-1:0] Q
);

  logic [WIDTH-1:0] value_q;
  logic [WIDTH-1:0] value_d;

  // Next-value selection; byte operations split the word at bit 8.
  always_comb begin
    value_d = value_q;
    if (E) begin
      case (fun_sel_e'(FunSel))
        DEC:         value_d = value_q - WIDTH'(1);
        INC:         value_d = value_q + WIDTH'(1);
        LOAD:        value_d = I;
        CLR:         value_d = '0;
        LOADLO_CLR:  value_d = {{(WIDTH-8){1'b0}}, I[7:0]};
        WRLO:        value_d = {value_q[WIDTH-1:8], I[7:0]};
        WRHI:        value_d = {I[7:0], value_q[7:0]};
        LOADLO_SEXT: value_d = {{(WIDTH-8){I[7]}}, I[7:0]};
        default:     value_d = value_q;
      endcase
    end
  end

  // State register; reset clears without waiting for the clock.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      value_q <= '0;
    end else begin
      value_q <= value_d;
    end
  end

  assign Q = value_q;

endmodule

// File: rtl/operand_register_file.sv
// Operand register file: general registers R1-R4 and scratch registers
// S1-S4, active-low write enables, two combinational read ports.
module operand_register_file
  import operand_register_file_pkg::*;
#(
  parameter int WIDTH = 16  // byte operations assume a 16-bit word
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic [WIDTH-1:0] I,
  input  logic [SEL_W-1:0] OutASel,
  input  logic [SEL_W-1:0] OutBSel,
  input  logic [FUN_W-1:0] FunSel,
  input  logic [3:0]       RegSel,
  input  logic [3:0]       ScrSel,
  output logic [WIDTH-1:0] OutA,
  output logic [WIDTH-1:0] OutB
);

  // Index 0..7 follows the read-select encoding: R1..R4, then S1..S4.
  logic [WIDTH-1:0] reg_value [NUM_REGS];
  logic [NUM_REGS-1:0] reg_enable;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
      // Select bits are MSB-first (bit3 = R1/S1), and active-low.
      if (gi < 4) begin : g_gen
        assign reg_enable[gi] = ~RegSel[3-gi];
      end else begin : g_scr
        assign reg_enable[gi] = ~ScrSel[7-gi];
      end

      register16 #(
        .WIDTH (WIDTH)
      ) u_reg (
        .Clock  (Clock),
        .Reset  (Reset),
        .E      (reg_enable[gi]),
        .FunSel (FunSel),
        .I      (I),
        .Q      (reg_value[gi])
      );
    end
  endgenerate

  // Read ports show current contents; a write appears after its edge.
  always_comb begin
    OutA = reg_value[OutASel];
    OutB = reg_value[OutBSel];
  end

endmodule
